// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule sequencer: loads 16 block words, expands W[16..63], streams W[0..63].
// Optional macro SHA256_MSG_SCHED_PIPE_EN registers the compressor outputs (2 cycles per expanded word).

module compressor_32b (
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [31:0] a4,
  input  logic [31:0] a5,
  input  logic [31:0] a6,
  input  logic [31:0] a7,
  output logic [31:0] sum1,
  output logic [31:0] sum2,
  output logic        ovfl
);
  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  logic [31:0] s0, c0, s1, c1, s2, c2, s3, c3, c4;

  // Carry-save tree of 3:2 counters; each carry vector moves up one bit, top carry is dropped
  always_comb begin
    s0   = a1 ^ a2 ^ a3;
    c0   = maj(a1, a2, a3);
    s1   = a4 ^ a5 ^ a6;
    c1   = maj(a4, a5, a6);
    s2   = s0 ^ {c0[30:0], 1'b0} ^ s1;
    c2   = maj(s0, {c0[30:0], 1'b0}, s1);
    s3   = s2 ^ {c1[30:0], 1'b0} ^ a7;
    c3   = maj(s2, {c1[30:0], 1'b0}, a7);
    sum1 = s3 ^ {c3[30:0], 1'b0} ^ {c2[30:0], 1'b0};
    c4   = maj(s3, {c3[30:0], 1'b0}, {c2[30:0], 1'b0});
    sum2 = {c4[30:0], 1'b0};
    ovfl = c0[31] | c1[31] | c2[31] | c3[31] | c4[31];
  end
endmodule

module sha256_msg_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [5:0]  w_index,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  state_t      state;
  logic [31:0] win [16];
  logic [5:0]  t;
  logic        out_free, load_xfer, exp_write, shift_en;
  logic [31:0] shift_word, sum1, sum2, w_new;
  logic        unused_ovfl;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  compressor_32b u_comp (
    .a1   (sig1(win[14])),
    .a2   (win[9]),
    .a3   (sig0(win[1])),
    .a4   (win[0]),
    .a5   (32'd0),
    .a6   (32'd0),
    .a7   (32'd0),
    .sum1 (sum1),
    .sum2 (sum2),
    .ovfl (unused_ovfl)
  );

  assign out_free  = !w_valid || w_ready;
  assign msg_ready = (state == LOAD) && out_free;
  assign load_xfer = msg_ready && msg_valid;
  assign busy      = (state != IDLE);

`ifdef SHA256_MSG_SCHED_PIPE_EN
  logic        phase;
  logic [31:0] sum1_q, sum2_q;

  assign exp_write = (state == EXPAND) && phase && out_free;
  assign w_new     = sum1_q + sum2_q;

  // phase 0 captures the compressor outputs, phase 1 waits for a free output slot to write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= 1'b0;
      sum1_q <= '0;
      sum2_q <= '0;
    end else if (state != EXPAND) begin
      phase <= 1'b0;
    end else if (!phase) begin
      sum1_q <= sum1;
      sum2_q <= sum2;
      phase  <= 1'b1;
    end else if (out_free) begin
      phase <= 1'b0;
    end
  end
`else
  assign exp_write = (state == EXPAND) && out_free;
  assign w_new     = sum1 + sum2;
`endif

  assign shift_en   = load_xfer || exp_write;
  assign shift_word = load_xfer ? msg_word : w_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= shift_word;
    end
  end

  // Every word entering the window is also the next word offered on the output stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      t       <= '0;
      w_valid <= 1'b0;
      w_data  <= '0;
      w_index <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (shift_en) begin
        w_data  <= shift_word;
        w_index <= t;
        w_valid <= 1'b1;
        t       <= t + 6'd1;
      end else if (w_ready) begin
        w_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            t     <= '0;
          end
        end
        LOAD:   if (load_xfer && t == 6'd15) state <= EXPAND;
        EXPAND: if (exp_write && t == 6'd63) state <= DONE;
        DONE: begin
          if (w_valid && w_ready && w_index == 6'd63) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched against a FIPS 180-4 schedule recurrence model.
// Honours SHA256_MSG_SCHED_PIPE_EN for the expected start-to-done latency.

module tb_sha256_msg_sched;
`ifdef SHA256_MSG_SCHED_PIPE_EN
  localparam int BLOCK_LAT = 114;
`else
  localparam int BLOCK_LAT = 66;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic [31:0] msg_word = '0;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [31:0] w_data;
  logic [5:0]  w_index;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc, done_cyc;
  int done_count = 0;
  int stall_errs = 0;
  int gap_errs = 0;
  bit rand_ready = 1'b0;

  logic [31:0] blk [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [$];
  logic [5:0]  got_i [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [5:0]  prev_idx;

  sha256_msg_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_word  (msg_word),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_index   (w_index),
    .busy      (busy),
    .done      (done)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Captures every accepted output word and watches for data changing under a stall
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!w_valid || w_data !== prev_data || w_index !== prev_idx)) stall_errs++;
      if (w_valid && w_ready) begin
        got_w.push_back(w_data);
        got_i.push_back(w_index);
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      prev_stall = w_valid && !w_ready;
      prev_data  = w_data;
      prev_idx   = w_index;
    end
  end

  initial begin
    #400000;
    fails++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic compute_ref();
    for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    compute_ref();
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    compute_ref();
  endtask

  // Called mid-cycle; start is sampled at the next rising edge
  task automatic send_block(input int gap);
    bit ok;
    int n;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    got_w.delete();
    got_i.delete();
    done_count = 0;
    stall_errs = 0;
    gap_errs   = 0;
    for (int i = 0; i < 16; i++) begin
      if (gap > 0 && i > 0) begin
        repeat (gap) begin
          msg_valid = 1'b0;
          @(negedge clk);
          if (msg_ready !== 1'b1) gap_errs++;
          @(posedge clk);
          #1;
        end
      end
      msg_valid = 1'b1;
      msg_word  = blk[i];
      n = 0;
      forever begin
        @(negedge clk);
        ok = msg_ready;
        @(posedge clk);
        #1;
        if (ok) break;
        n++;
        if (n > 300) begin
          tests++;
          fails++;
          $display("[TB] FAIL load timeout: word %0d not accepted, msg_ready=%b want 1", i, msg_ready);
          break;
        end
      end
    end
    msg_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_count == 0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_count == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL done timeout: done_count=%0d want 1", done_count);
    end
  endtask

  task automatic test_reset();
    logic [41:0] obs;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = {msg_ready, w_valid, w_data, w_index, busy, done};
    tests++;
    if (obs !== 42'd0) begin
      fails++;
      $display("[TB] FAIL reset outputs: got rdy=%b vld=%b data=%h idx=%0d busy=%b done=%b, want all 0",
               msg_ready, w_valid, w_data, w_index, busy, done);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_abc();
    rand_ready = 1'b0;
    load_abc();
    send_block(0);
    wait_done();
    tests++;
    if (got_w.size() !== 64) begin
      fails++;
      $display("[TB] FAIL abc count: got %0d words, want 64", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 64; i++) begin
      tests++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 6'(i)) begin
        fails++;
        $display("[TB] FAIL abc W[%0d]: got %h idx %0d, want %h idx %0d", i, got_w[i], got_i[i], exp_w[i], i);
      end
    end
    if (got_w.size() == 64) begin
      tests += 3;
      if (got_w[16] !== 32'h61626380) begin
        fails++;
        $display("[TB] FAIL abc W16: got %h want 61626380", got_w[16]);
      end
      if (got_w[17] !== 32'h000F0000) begin
        fails++;
        $display("[TB] FAIL abc W17: got %h want 000f0000", got_w[17]);
      end
      if (got_w[63] !== 32'h12B1EDEB) begin
        fails++;
        $display("[TB] FAIL abc W63: got %h want 12b1edeb", got_w[63]);
      end
    end
    tests += 2;
    if (done_cyc - start_cyc !== BLOCK_LAT) begin
      fails++;
      $display("[TB] FAIL abc latency: got %0d cycles want %0d", done_cyc - start_cyc, BLOCK_LAT);
    end
    if (done_count !== 1) begin
      fails++;
      $display("[TB] FAIL abc done pulses: got %0d want 1", done_count);
    end
  endtask

  task automatic test_backpressure();
    load_abc();
    rand_ready = 1'b1;
    send_block(0);
    wait_done();
    rand_ready = 1'b0;
    tests++;
    if (got_w.size() !== 64) begin
      fails++;
      $display("[TB] FAIL backpressure count: got %0d words, want 64", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 64; i++) begin
      tests++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 6'(i)) begin
        fails++;
        $display("[TB] FAIL backpressure W[%0d]: got %h idx %0d, want %h idx %0d", i, got_w[i], got_i[i], exp_w[i], i);
      end
    end
    tests += 2;
    if (stall_errs !== 0) begin
      fails++;
      $display("[TB] FAIL backpressure stability: %0d changes while stalled, want 0", stall_errs);
    end
    if (done_count !== 1) begin
      fails++;
      $display("[TB] FAIL backpressure done pulses: got %0d want 1", done_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_source_gaps();
    load_random();
    send_block(3);
    wait_done();
    tests++;
    if (got_w.size() !== 64) begin
      fails++;
      $display("[TB] FAIL gaps count: got %0d words, want 64", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 64; i++) begin
      tests++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 6'(i)) begin
        fails++;
        $display("[TB] FAIL gaps W[%0d]: got %h idx %0d, want %h idx %0d", i, got_w[i], got_i[i], exp_w[i], i);
      end
    end
    tests++;
    if (gap_errs !== 0) begin
      fails++;
      $display("[TB] FAIL gaps msg_ready: dropped %0d times during gaps, want 0", gap_errs);
    end
  endtask

  task automatic test_ignored_start();
    int n = 0;
    load_random();
    send_block(0);
    while (!(w_valid && w_index == 6'd20) && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    #1;
    tests++;
    if (got_w.size() !== 64) begin
      fails++;
      $display("[TB] FAIL ignored-start count: got %0d words, want 64", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 64; i++) begin
      tests++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 6'(i)) begin
        fails++;
        $display("[TB] FAIL ignored-start W[%0d]: got %h idx %0d, want %h idx %0d", i, got_w[i], got_i[i], exp_w[i], i);
      end
    end
    tests += 2;
    if (done_count !== 1) begin
      fails++;
      $display("[TB] FAIL ignored-start done pulses: got %0d want 1", done_count);
    end
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ignored-start restart: busy=%b want 0", busy);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    logic [41:0] obs;
    load_random();
    send_block(0);
    while (!(w_valid && w_index == 6'd40) && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    if (!(w_valid && w_index == 6'd40)) begin
      fails++;
      $display("[TB] FAIL mid-reset reach t=40: w_valid=%b idx=%0d want 1/40", w_valid, w_index);
    end
    rst_n = 1'b0;
    #1;
    obs = {msg_ready, w_valid, w_data, w_index, busy, done};
    tests++;
    if (obs !== 42'd0) begin
      fails++;
      $display("[TB] FAIL mid-reset outputs: got rdy=%b vld=%b data=%h idx=%0d busy=%b done=%b, want all 0",
               msg_ready, w_valid, w_data, w_index, busy, done);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_random();
    send_block(0);
    wait_done();
    tests++;
    if (got_w.size() !== 64) begin
      fails++;
      $display("[TB] FAIL post-reset count: got %0d words, want 64", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 64; i++) begin
      tests++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 6'(i)) begin
        fails++;
        $display("[TB] FAIL post-reset W[%0d]: got %h idx %0d, want %h idx %0d", i, got_w[i], got_i[i], exp_w[i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    load_random();
    send_block(0);
    wait_done();
    tests++;
    if (got_w.size() !== 64) begin
      fails++;
      $display("[TB] FAIL b2b first count: got %0d words, want 64", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 64; i++) begin
      tests++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 6'(i)) begin
        fails++;
        $display("[TB] FAIL b2b first W[%0d]: got %h idx %0d, want %h idx %0d", i, got_w[i], got_i[i], exp_w[i], i);
      end
    end
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    compute_ref();
    send_block(0);
    wait_done();
    tests++;
    if (got_w.size() !== 64) begin
      fails++;
      $display("[TB] FAIL b2b second count: got %0d words, want 64", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 64; i++) begin
      tests++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 6'(i)) begin
        fails++;
        $display("[TB] FAIL b2b second W[%0d]: got %h idx %0d, want %h idx %0d", i, got_w[i], got_i[i], exp_w[i], i);
      end
    end
    tests += 2;
    if (done_cyc - start_cyc !== BLOCK_LAT) begin
      fails++;
      $display("[TB] FAIL b2b latency: got %0d cycles want %0d", done_cyc - start_cyc, BLOCK_LAT);
    end
    if (done_count !== 1) begin
      fails++;
      $display("[TB] FAIL b2b done pulses: got %0d want 1", done_count);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_backpressure();
    test_source_gaps();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
